// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with combinational lookup and registered update.
// Define BHT_GSHARE_EN to XOR a global history register into the lookup index (gshare); default is bimodal.
module bht_predictor #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int INDEX_LSB = 2,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_en,
    input  logic [31:0]      lookup_pc,
    input  logic [31:0]      offset,
    output logic [31:0]      branch_addr,
    output logic             prediction,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             update_en,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             update_taken,
    input  logic             update_pred,
    output logic [15:0]      mispredict_cnt
);

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_BITS-1:0] CTR_RST = (CTR_BITS == 1) ? '0 :
                                              CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [CTR_BITS-1:0] ctr_reg [ENTRIES];
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_next;
    logic [15:0]         mis_reg;
    logic [IDX_W-1:0]    pc_slice;

    assign branch_addr = lookup_pc + offset;
    assign pc_slice    = lookup_pc[INDEX_LSB +: IDX_W];

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg <= '0;
        end else if (update_en) begin
            ghr_reg <= {ghr_reg[IDX_W-2:0], update_taken};
        end
    end

    assign pred_idx = pc_slice ^ ghr_reg;
`else
    assign pred_idx = pc_slice;
`endif

    // Lookup reads the pre-update table; there is deliberately no bypass from the update port.
    assign prediction = lookup_en & rst_n & ctr_reg[pred_idx][CTR_BITS-1];

    assign ctr_cur = ctr_reg[update_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (update_taken) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_RST;
        end else if (update_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (update_idx == IDX_W'(i)) ctr_reg[i] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_reg <= '0;
        end else if (update_en && (update_taken != update_pred) && (mis_reg != 16'hFFFF)) begin
            mis_reg <= mis_reg + 16'd1;
        end
    end

    assign mispredict_cnt = mis_reg;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus randomized traffic against a table model.
module tb_bht_predictor;
    localparam int ENTRIES   = 16;
    localparam int CTR_BITS  = 2;
    localparam int INDEX_LSB = 2;
    localparam int IDX_W     = 4;
    localparam int CMAX      = (1 << CTR_BITS) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lookup_en;
    logic [31:0]      lookup_pc;
    logic [31:0]      offset;
    logic [31:0]      branch_addr;
    logic             prediction;
    logic [IDX_W-1:0] pred_idx;
    logic             update_en;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             update_pred;
    logic [15:0]      mispredict_cnt;

    int model_ctr [ENTRIES];
    int model_ghr;
    int model_mis;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bht_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .INDEX_LSB(INDEX_LSB)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc), .offset(offset),
        .branch_addr(branch_addr), .prediction(prediction), .pred_idx(pred_idx),
        .update_en(update_en), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred(update_pred),
        .mispredict_cnt(mispredict_cnt)
    );

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++)
            model_ctr[i] = (CTR_BITS == 1) ? 0 : (1 << (CTR_BITS - 1)) - 1;
        model_ghr = 0;
        model_mis = 0;
    endfunction

    function automatic int model_idx(logic [31:0] pc);
        return int'((pc >> INDEX_LSB) & (ENTRIES - 1)) ^ model_ghr;
    endfunction

    // A PC (with random upper bits) that maps to table entry idx under the current history.
    function automatic logic [31:0] pc_for(int idx);
        logic [31:0] hi;
        hi = $urandom & ~(32'(ENTRIES - 1) << INDEX_LSB);
        return hi | (32'(idx ^ model_ghr) << INDEX_LSB);
    endfunction

    function automatic logic model_pred(logic en, logic [31:0] pc);
        return en && (model_ctr[model_idx(pc)] >= (1 << (CTR_BITS - 1)));
    endfunction

    task automatic set_update(logic en, int idx, logic taken, logic pred);
        update_en    = en;
        update_idx   = IDX_W'(idx);
        update_taken = taken;
        update_pred  = pred;
    endtask

    // Advance one clock; the model applies the update the DUT sees on the same edge.
    task automatic tick();
        int idx;
        @(posedge clk);
        if (rst_n === 1'b1 && update_en === 1'b1) begin
            idx = int'(update_idx);
            if (update_taken) model_ctr[idx] = (model_ctr[idx] + 1 > CMAX) ? CMAX : model_ctr[idx] + 1;
            else              model_ctr[idx] = (model_ctr[idx] - 1 < 0) ? 0 : model_ctr[idx] - 1;
            if (update_taken != update_pred) model_mis = (model_mis + 1 > 65535) ? 65535 : model_mis + 1;
`ifdef BHT_GSHARE_EN
            model_ghr = ((model_ghr << 1) | int'(update_taken)) & (ENTRIES - 1);
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_update(1'b0, 0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // An update is held active across a reset edge; it must be discarded.
        rst_n = 1'b0;
        lookup_en = 1'b1; lookup_pc = 32'h0000_0040; offset = 32'h0;
        set_update(1'b1, 0, 1'b1, 1'b0);
        model_reset();
        #2;
        n_cmp++; if (prediction !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b expected 0", prediction); end
        n_cmp++; if (pred_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", pred_idx); end
        n_cmp++; if (mispredict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mis: got %0d expected 0", mispredict_cnt); end
        tick();
        tick();
        rst_n = 1'b1;
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(0);
        #1;
        n_cmp++; if (prediction !== 1'b0) begin n_err++; $display("FAIL reset_discard_pred: got %b expected 0", prediction); end
        n_cmp++; if (mispredict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_discard_mis: got %0d expected 0", mispredict_cnt); end
        $display("reset: pred=%b idx=%0d mis=%0d", prediction, pred_idx, mispredict_cnt);
    endtask

    task automatic test_training();
        do_reset();
        lookup_en = 1'b1;
        set_update(1'b1, 0, 1'b1, 1'b0);
        tick();
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(0);
        #1;
        n_cmp++; if (prediction !== 1'b1) begin n_err++; $display("FAIL train_pred: got %b expected 1", prediction); end
        n_cmp++; if (mispredict_cnt !== 16'd2) begin n_err++; $display("FAIL train_mis: got %0d expected 2", mispredict_cnt); end
        // Third taken saturates at 3; a not-taken afterwards must still predict taken.
        set_update(1'b1, 0, 1'b1, 1'b1);
        tick();
        set_update(1'b1, 0, 1'b0, 1'b0);
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(0);
        #1;
        n_cmp++; if (prediction !== model_pred(1'b1, lookup_pc) || prediction !== 1'b1) begin
            n_err++; $display("FAIL train_sat_hi: got %b expected 1", prediction); end
        n_cmp++; if (mispredict_cnt !== 16'(model_mis)) begin
            n_err++; $display("FAIL train_mis2: got %0d expected %0d", mispredict_cnt, model_mis); end
        $display("training: idx0 pred=%b mis=%0d", prediction, mispredict_cnt);
    endtask

    task automatic test_sat_zero();
        do_reset();
        lookup_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_update(1'b1, 5, 1'b0, 1'b1);
            tick();
        end
        set_update(1'b1, 5, 1'b1, 1'b0);
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(5);
        #1;
        n_cmp++; if (prediction !== 1'b0) begin n_err++; $display("FAIL sat_lo_pred: got %b expected 0", prediction); end
        n_cmp++; if (mispredict_cnt !== 16'd5) begin n_err++; $display("FAIL sat_lo_mis: got %0d expected 5", mispredict_cnt); end
        // Counter is now 1: one more taken must flip the prediction.
        set_update(1'b1, 5, 1'b1, 1'b0);
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(5);
        #1;
        n_cmp++; if (prediction !== 1'b1) begin n_err++; $display("FAIL sat_lo_recover: got %b expected 1", prediction); end
        $display("sat_zero: idx5 pred=%b mis=%0d", prediction, mispredict_cnt);
    endtask

    task automatic test_collision();
        do_reset();
        lookup_en = 1'b1;
        lookup_pc = pc_for(3);
        set_update(1'b1, 3, 1'b1, 1'b0);
        #1;
        n_cmp++; if (prediction !== 1'b0) begin n_err++; $display("FAIL collide_same: got %b expected 0", prediction); end
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(3);
        #1;
        n_cmp++; if (prediction !== 1'b1) begin n_err++; $display("FAIL collide_next: got %b expected 1", prediction); end
        $display("collision: next pred=%b", prediction);
    endtask

    task automatic test_arith_gating();
        logic [31:0] exp_addr;
        lookup_pc = 32'hFFFF_FFF0; offset = 32'h0000_0020;
        #1;
        n_cmp++; if (branch_addr !== 32'h0000_0010) begin
            n_err++; $display("FAIL addr_wrap: got %h expected 00000010", branch_addr); end
        for (int k = 0; k < 6; k++) begin
            lookup_pc = $urandom; offset = $urandom;
            exp_addr = 32'((longint'(lookup_pc) + longint'(offset)) % 64'h1_0000_0000);
            #1;
            n_cmp++; if (branch_addr !== exp_addr) begin
                n_err++; $display("FAIL addr_rand: got %h expected %h", branch_addr, exp_addr); end
        end
        do_reset();
        set_update(1'b1, 7, 1'b1, 1'b1);
        tick();
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_en = 1'b0;
        lookup_pc = pc_for(7);
        #1;
        n_cmp++; if (prediction !== 1'b0) begin n_err++; $display("FAIL gate_off: got %b expected 0", prediction); end
        lookup_en = 1'b1;
        #1;
        n_cmp++; if (prediction !== 1'b1) begin n_err++; $display("FAIL gate_on: got %b expected 1", prediction); end
        $display("arith_gating: addr ok, gated pred checked");
    endtask

    task automatic test_history();
        do_reset();
        lookup_en = 1'b1;
        set_update(1'b1, 0, 1'b1, 1'b1); tick();
        set_update(1'b1, 0, 1'b0, 1'b0); tick();
        set_update(1'b1, 0, 1'b1, 1'b1); tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = 32'h0000_0008;
        #1;
`ifdef BHT_GSHARE_EN
        n_cmp++; if (pred_idx !== 4'b0111) begin n_err++; $display("FAIL gshare_idx: got %b expected 0111", pred_idx); end
`else
        n_cmp++; if (pred_idx !== 4'b0010) begin n_err++; $display("FAIL bimodal_idx: got %b expected 0010", pred_idx); end
`endif
        $display("history: pc=%h idx=%b", lookup_pc, pred_idx);
    endtask

    task automatic test_mid_reset();
        do_reset();
        lookup_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_update(1'b1, 4 + (k % 2) * 5, 1'b1, 1'b0);
            tick();
        end
        set_update(1'b1, 9, 1'b1, 1'b0);
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        // Assert reset between edges; state must clear without a clock.
        lookup_pc = 32'h0000_0008;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (mispredict_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_mis: got %0d expected 0", mispredict_cnt); end
        n_cmp++; if (pred_idx !== 4'b0010) begin n_err++; $display("FAIL midrst_idx: got %b expected 0010", pred_idx); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup_pc = pc_for(i);
            #1;
            n_cmp++; if (prediction !== 1'b0) begin
                n_err++; $display("FAIL midrst_ctr%0d: got %b expected 0", i, prediction); end
        end
        // First edge after release must apply normally.
        @(posedge clk); #1;
        set_update(1'b1, 9, 1'b1, 1'b0);
        tick();
        set_update(1'b0, 0, 1'b0, 1'b0);
        lookup_pc = pc_for(9);
        #1;
        n_cmp++; if (prediction !== 1'b1) begin n_err++; $display("FAIL midrst_first: got %b expected 1", prediction); end
        n_cmp++; if (mispredict_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_first_mis: got %0d expected 1", mispredict_cnt); end
        $display("mid_reset: restored, first update pred=%b", prediction);
    endtask

    task automatic test_random();
        logic        exp_pred;
        logic [31:0] exp_addr;
        int          exp_idx;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            lookup_en = 1'($urandom_range(0, 3) != 0);
            lookup_pc = $urandom;
            offset    = $urandom;
            set_update(1'($urandom_range(0, 9) < 6), $urandom_range(0, ENTRIES - 1),
                       1'($urandom), 1'($urandom));
            #1;
            exp_idx  = model_idx(lookup_pc);
            exp_pred = model_pred(lookup_en, lookup_pc);
            exp_addr = 32'((longint'(lookup_pc) + longint'(offset)) % 64'h1_0000_0000);
            n_cmp++; if (pred_idx !== IDX_W'(exp_idx)) begin
                n_err++; $display("FAIL rnd_idx[%0d]: got %0d expected %0d", k, pred_idx, exp_idx); end
            n_cmp++; if (prediction !== exp_pred) begin
                n_err++; $display("FAIL rnd_pred[%0d]: got %b expected %b", k, prediction, exp_pred); end
            n_cmp++; if (branch_addr !== exp_addr) begin
                n_err++; $display("FAIL rnd_addr[%0d]: got %h expected %h", k, branch_addr, exp_addr); end
            n_cmp++; if (mispredict_cnt !== 16'(model_mis)) begin
                n_err++; $display("FAIL rnd_mis[%0d]: got %0d expected %0d", k, mispredict_cnt, model_mis); end
            $display("rnd %0d: en=%b pc=%h idx=%0d pred=%b upd=%b/%0d/%b/%b mis=%0d",
                     k, lookup_en, lookup_pc, pred_idx, prediction,
                     update_en, update_idx, update_taken, update_pred, mispredict_cnt);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lookup_en = 1'b0; lookup_pc = '0; offset = '0;
        set_update(1'b0, 0, 1'b0, 1'b0);
        test_reset();
        test_training();
        test_sat_zero();
        test_collision();
        test_arith_gating();
        test_history();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
